// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared states, opcode constants and PC step for cpu_control
package cpu_pkg;

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_MEM,
        ST_WB,
        ST_HALT
    } state_t;

    typedef enum logic [2:0] {
        CLS_NOP,
        CLS_LOADI,
        CLS_ADD,
        CLS_STORE,
        CLS_HALT,
        CLS_ILLEGAL
    } op_class_t;

    localparam logic [3:0] OP_NOP   = 4'h0;
    localparam logic [3:0] OP_LOADI = 4'h1;
    localparam logic [3:0] OP_ADD   = 4'h8;
    localparam logic [3:0] OP_STORE = 4'h3;
    localparam logic [3:0] OP_HALT  = 4'hF;

    localparam logic [7:0] PC_STEP = 8'd2;

endpackage

// File: rtl/instr_decode.sv
// rtl/instr_decode.sv - combinational split of the two-byte instruction into fields
module instr_decode
    import cpu_pkg::*;
(
    input  logic [7:0] ir1,
    input  logic [7:0] ir2,
    output op_class_t  op_class,
    output logic [3:0] rd,
    output logic [3:0] rs1,
    output logic [3:0] rs2,
    output logic [7:0] imm,
    output logic       illegal
);

    always_comb begin
        op_class = CLS_ILLEGAL;
        illegal  = 1'b0;
        rs1      = ir1[3:0];
        rs2      = ir2[7:4];
        rd       = ir2[3:0];
        imm      = ir2;
        case (ir1[7:4])
            OP_NOP:   op_class = CLS_NOP;
            OP_LOADI: begin
                op_class = CLS_LOADI;
                // LOADI carries its destination in the first byte, ADD in the second
                rd       = ir1[3:0];
            end
            OP_ADD:   op_class = CLS_ADD;
            OP_STORE: op_class = CLS_STORE;
            OP_HALT:  op_class = CLS_HALT;
            default:  illegal  = 1'b1;
        endcase
    end

endmodule

// File: rtl/cpu_control.sv
// rtl/cpu_control.sv - multi-cycle fetch/decode/execute controller with PC and HALT
module cpu_control
    import cpu_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] opcode1,
    input  logic [7:0] opcode2,
    input  logic       mem_ready,
    output logic [7:0] rom_address,
    output logic [3:0] rf_raddr_a,
    output logic [3:0] rf_raddr_b,
    output logic       rf_we,
    output logic [3:0] rf_waddr,
    output logic       wb_sel,
    output logic [7:0] imm,
    output logic       mem_we,
    output logic [7:0] mem_addr,
    output logic       halted,
    output logic       illegal
);

    state_t     state;
    state_t     state_next;
    logic [7:0] pc;
    logic [7:0] ir1;
    logic [7:0] ir2;
    logic       illegal_q;
    logic       pc_advance;
    logic       set_illegal;

    op_class_t  dec_class;
    logic [3:0] dec_rd;
    logic [3:0] dec_rs1;
    logic [3:0] dec_rs2;
    logic [7:0] dec_imm;
    logic       dec_illegal;

    instr_decode u_decode (
        .ir1      (ir1),
        .ir2      (ir2),
        .op_class (dec_class),
        .rd       (dec_rd),
        .rs1      (dec_rs1),
        .rs2      (dec_rs2),
        .imm      (dec_imm),
        .illegal  (dec_illegal)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_FETCH;
            pc        <= 8'd0;
            ir1       <= 8'd0;
            ir2       <= 8'd0;
            illegal_q <= 1'b0;
        end else begin
            state <= state_next;
            if (state == ST_FETCH) begin
                ir1 <= opcode1;
                ir2 <= opcode2;
            end
            if (pc_advance)
                pc <= pc + PC_STEP;
            if (set_illegal)
                illegal_q <= 1'b1;
        end
    end

    // Strobes decode straight from the state register so reset kills them at once
    always_comb begin
        state_next  = state;
        pc_advance  = 1'b0;
        set_illegal = 1'b0;
        rf_we       = 1'b0;
        mem_we      = 1'b0;
        wb_sel      = 1'b0;
        case (state)
            ST_FETCH:  state_next = ST_DECODE;
            ST_DECODE: begin
                if (dec_illegal) begin
                    state_next  = ST_HALT;
                    set_illegal = 1'b1;
                end else begin
                    case (dec_class)
                        CLS_NOP: begin
                            state_next = ST_FETCH;
                            pc_advance = 1'b1;
                        end
                        CLS_LOADI: state_next = ST_WB;
                        CLS_ADD:   state_next = ST_EXEC;
                        CLS_STORE: state_next = ST_MEM;
                        default:   state_next = ST_HALT;
                    endcase
                end
            end
            ST_EXEC:   state_next = ST_WB;
            ST_WB: begin
                rf_we      = 1'b1;
                wb_sel     = (dec_class == CLS_ADD);
                state_next = ST_FETCH;
                pc_advance = 1'b1;
            end
            ST_MEM: begin
                mem_we = 1'b1;
                if (mem_ready) begin
                    state_next = ST_FETCH;
                    pc_advance = 1'b1;
                end
            end
            ST_HALT:   state_next = ST_HALT;
            default:   state_next = ST_FETCH;
        endcase
    end

    assign rom_address = pc;
    assign rf_raddr_a  = dec_rs1;
    assign rf_raddr_b  = dec_rs2;
    assign rf_waddr    = dec_rd;
    assign imm         = dec_imm;
    assign mem_addr    = ir2;
    assign halted      = (state == ST_HALT);
    assign illegal     = illegal_q;

endmodule

// File: tb/tb_cpu_control.sv
// tb/tb_cpu_control.sv - directed self-checking bench for cpu_control
module tb_cpu_control;

    logic       clk;
    logic       reset;
    logic [7:0] opcode1;
    logic [7:0] opcode2;
    logic       mem_ready;
    logic [7:0] rom_address;
    logic [3:0] rf_raddr_a;
    logic [3:0] rf_raddr_b;
    logic       rf_we;
    logic [3:0] rf_waddr;
    logic       wb_sel;
    logic [7:0] imm;
    logic       mem_we;
    logic [7:0] mem_addr;
    logic       halted;
    logic       illegal;

    logic [7:0] rom [256];
    logic [7:0] addr_p1;

    int total;
    int bad;
    int rf_pulses;
    int mem_pulses;
    int overlap;

    cpu_control dut (
        .clk         (clk),
        .reset       (reset),
        .opcode1     (opcode1),
        .opcode2     (opcode2),
        .mem_ready   (mem_ready),
        .rom_address (rom_address),
        .rf_raddr_a  (rf_raddr_a),
        .rf_raddr_b  (rf_raddr_b),
        .rf_we       (rf_we),
        .rf_waddr    (rf_waddr),
        .wb_sel      (wb_sel),
        .imm         (imm),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .halted      (halted),
        .illegal     (illegal)
    );

    assign addr_p1 = rom_address + 8'd1;
    assign opcode1 = rom[rom_address];
    assign opcode2 = rom[addr_p1];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog time limit expired");
        $fatal(1, "watchdog");
    end

    task automatic clear_rom();
        for (int i = 0; i < 256; i++) rom[i] = 8'h00;
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (rf_we) rf_pulses++;
            if (mem_we) mem_pulses++;
            if (rf_we && mem_we) overlap++;
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        rf_pulses  = 0;
        mem_pulses = 0;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 256; i++) rom[i] = 8'h33;
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        total++; if (rom_address !== 8'd0) begin bad++; $display("FAIL reset_pc got=%0d exp=0", rom_address); end
        total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL reset_rf_we got=%b exp=0", rf_we); end
        total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL reset_mem_we got=%b exp=0", mem_we); end
        total++; if (mem_addr !== 8'd0) begin bad++; $display("FAIL reset_mem_addr got=%h exp=00", mem_addr); end
        total++; if (imm !== 8'd0) begin bad++; $display("FAIL reset_imm got=%h exp=00", imm); end
        total++; if ({halted, illegal, wb_sel} !== 3'b000) begin bad++; $display("FAIL reset_flags got=%b exp=000", {halted, illegal, wb_sel}); end
    endtask

    task automatic test_nop_halt();
        int k;
        clear_rom();
        rom[4] = 8'hF0;
        apply_reset();
        total++; if (rom_address !== 8'd0) begin bad++; $display("FAIL nop_pc0 got=%0d exp=0", rom_address); end
        step(2);
        total++; if (rom_address !== 8'd2) begin bad++; $display("FAIL nop_pc2 got=%0d exp=2", rom_address); end
        step(2);
        total++; if (rom_address !== 8'd4) begin bad++; $display("FAIL nop_pc4 got=%0d exp=4", rom_address); end
        k = 0;
        while (!halted && k < 4) begin
            step(1);
            k++;
        end
        total++; if (halted !== 1'b1) begin bad++; $display("FAIL halt_reached got=%b exp=1", halted); end
        step(5);
        total++; if (rom_address !== 8'd4) begin bad++; $display("FAIL halt_pc_frozen got=%0d exp=4", rom_address); end
        total++; if (rf_pulses + mem_pulses !== 0) begin bad++; $display("FAIL nop_no_strobes got=%0d exp=0", rf_pulses + mem_pulses); end
    endtask

    task automatic test_loadi();
        clear_rom();
        rom[2] = 8'h10;
        rom[3] = 8'hFF;
        rom[4] = 8'hF0;
        apply_reset();
        step(3);
        total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL loadi_decode_rf_we got=%b exp=0", rf_we); end
        step(1);
        total++; if (rf_we !== 1'b1) begin bad++; $display("FAIL loadi_rf_we got=%b exp=1", rf_we); end
        total++; if (rf_waddr !== 4'd0) begin bad++; $display("FAIL loadi_waddr got=%0d exp=0", rf_waddr); end
        total++; if (wb_sel !== 1'b0) begin bad++; $display("FAIL loadi_wb_sel got=%b exp=0", wb_sel); end
        total++; if (imm !== 8'hFF) begin bad++; $display("FAIL loadi_imm got=%h exp=ff", imm); end
        step(1);
        total++; if (rom_address !== 8'd4) begin bad++; $display("FAIL loadi_pc got=%0d exp=4", rom_address); end
        total++; if (rf_pulses !== 1) begin bad++; $display("FAIL loadi_pulses got=%0d exp=1", rf_pulses); end
    endtask

    task automatic test_add();
        clear_rom();
        rom[0] = 8'h80;
        rom[1] = 8'h13;
        rom[2] = 8'h8A;
        rom[3] = 8'h5C;
        rom[4] = 8'hF0;
        apply_reset();
        step(1);
        total++; if ({rf_raddr_a, rf_raddr_b} !== 8'h01) begin bad++; $display("FAIL add_raddr got=%h exp=01", {rf_raddr_a, rf_raddr_b}); end
        step(1);
        total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL add_exec_rf_we got=%b exp=0", rf_we); end
        step(1);
        total++; if ({rf_we, wb_sel, rf_waddr} !== 6'b11_0011) begin bad++; $display("FAIL add_wb got=%b exp=110011", {rf_we, wb_sel, rf_waddr}); end
        step(1);
        total++; if (rom_address !== 8'd2) begin bad++; $display("FAIL add_pc got=%0d exp=2", rom_address); end
        step(1);
        total++; if ({rf_raddr_a, rf_raddr_b} !== 8'hA5) begin bad++; $display("FAIL add2_raddr got=%h exp=a5", {rf_raddr_a, rf_raddr_b}); end
        step(2);
        total++; if ({rf_we, wb_sel, rf_waddr} !== 6'b11_1100) begin bad++; $display("FAIL add2_wb got=%b exp=111100", {rf_we, wb_sel, rf_waddr}); end
        step(1);
        total++; if (rom_address !== 8'd4) begin bad++; $display("FAIL add2_pc got=%0d exp=4", rom_address); end
        total++; if (rf_pulses !== 2) begin bad++; $display("FAIL add_pulses got=%0d exp=2", rf_pulses); end
    endtask

    task automatic test_store();
        clear_rom();
        rom[0] = 8'h33;
        rom[1] = 8'h82;
        rom[2] = 8'hF0;
        mem_ready = 1'b0;
        apply_reset();
        step(2);
        for (int i = 0; i < 3; i++) begin
            total++; if ({mem_we, rf_we, mem_addr, rf_raddr_a} !== {2'b10, 8'h82, 4'd3}) begin bad++; $display("FAIL store_wait%0d got=%h exp=%h", i, {mem_we, rf_we, mem_addr, rf_raddr_a}, {2'b10, 8'h82, 4'd3}); end
            total++; if (rom_address !== 8'd0) begin bad++; $display("FAIL store_wait_pc%0d got=%0d exp=0", i, rom_address); end
            step(1);
        end
        mem_ready = 1'b1;
        total++; if (mem_we !== 1'b1) begin bad++; $display("FAIL store_ready_mem_we got=%b exp=1", mem_we); end
        step(1);
        mem_ready = 1'b0;
        total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL store_done_mem_we got=%b exp=0", mem_we); end
        total++; if (rom_address !== 8'd2) begin bad++; $display("FAIL store_pc got=%0d exp=2", rom_address); end
        total++; if (mem_pulses !== 4) begin bad++; $display("FAIL store_cycles got=%0d exp=4", mem_pulses); end
        step(4);
        total++; if (rom_address !== 8'd2) begin bad++; $display("FAIL store_single_advance got=%0d exp=2", rom_address); end
    endtask

    task automatic test_illegal();
        clear_rom();
        rom[2] = 8'h50;
        apply_reset();
        step(3);
        total++; if ({illegal, halted} !== 2'b00) begin bad++; $display("FAIL illegal_early got=%b exp=00", {illegal, halted}); end
        step(1);
        total++; if ({illegal, halted} !== 2'b11) begin bad++; $display("FAIL illegal_set got=%b exp=11", {illegal, halted}); end
        step(3);
        total++; if (rom_address !== 8'd2) begin bad++; $display("FAIL illegal_pc_frozen got=%0d exp=2", rom_address); end
        total++; if (illegal !== 1'b1) begin bad++; $display("FAIL illegal_sticky got=%b exp=1", illegal); end
        reset = 1'b1;
        #1;
        total++; if ({illegal, halted, rom_address} !== 10'd0) begin bad++; $display("FAIL illegal_reset_clear got=%b exp=0", {illegal, halted, rom_address}); end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset_mid_store();
        clear_rom();
        rom[0] = 8'h33;
        rom[1] = 8'h44;
        mem_ready = 1'b0;
        apply_reset();
        step(2);
        total++; if ({mem_we, mem_addr} !== 9'h144) begin bad++; $display("FAIL abort_pre got=%h exp=144", {mem_we, mem_addr}); end
        reset = 1'b1;
        #1;
        total++; if ({mem_we, rom_address} !== 9'd0) begin bad++; $display("FAIL abort_async got=%h exp=0", {mem_we, rom_address}); end
        rf_pulses  = 0;
        mem_pulses = 0;
        step(3);
        reset = 1'b0;
        total++; if (rf_pulses + mem_pulses !== 0) begin bad++; $display("FAIL abort_no_strobes got=%0d exp=0", rf_pulses + mem_pulses); end
    endtask

    task automatic test_pc_wrap();
        clear_rom();
        apply_reset();
        step(254);
        total++; if (rom_address !== 8'd254) begin bad++; $display("FAIL wrap_pc254 got=%0d exp=254", rom_address); end
        step(2);
        total++; if (rom_address !== 8'd0) begin bad++; $display("FAIL wrap_pc0 got=%0d exp=0", rom_address); end
        total++; if (rf_pulses + mem_pulses !== 0) begin bad++; $display("FAIL wrap_no_strobes got=%0d exp=0", rf_pulses + mem_pulses); end
    endtask

    initial begin
        total      = 0;
        bad        = 0;
        rf_pulses  = 0;
        mem_pulses = 0;
        overlap    = 0;
        reset      = 1'b1;
        mem_ready  = 1'b0;
        test_reset();
        test_nop_halt();
        test_loadi();
        test_add();
        test_store();
        test_illegal();
        test_reset_mid_store();
        test_pc_wrap();
        total++; if (overlap !== 0) begin bad++; $display("FAIL we_overlap got=%0d exp=0", overlap); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cpu_control.md
CPU_CONTROL -- requirements
Module: cpu_control

Interface
REQ-001 The block SHALL have one clock and one reset; reset is asynchronous and active-high.
REQ-002 clk  input  1  system clock, all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 opcode1  input  8  instruction byte at rom_address.
REQ-005 opcode2  input  8  instruction byte at rom_address+1.
REQ-006 mem_ready  input  1  data-memory write accepted this cycle.
REQ-007 rom_address  output  8  program counter (PC) driven to ROM.
REQ-008 rf_raddr_a / rf_raddr_b  output  4 each  register-file read addresses.
REQ-009 rf_we  output  1  register-file write strobe; rf_waddr  output  4  write address.
REQ-010 wb_sel  output  1  write-back source: 0 = imm, 1 = ALU sum.
REQ-011 imm  output  8  immediate byte (IR opcode2).
REQ-012 mem_we  output  1  data-memory write request; mem_addr  output  8  its address.
REQ-013 halted  output  1  high while in HALT; illegal  output  1  sticky illegal-opcode flag.

Function
REQ-014 Encoding (IR1 = latched opcode1, IR2 = latched opcode2): IR1[7:4]=0000 NOP; 0001 LOADI rd=IR1[3:0], imm=IR2; 1000 ADD rs1=IR1[3:0], rs2=IR2[7:4], rd=IR2[3:0]; 0011 STORE rs=IR1[3:0], addr=IR2; 1111 HALT; all others illegal.
REQ-015 States SHALL be FETCH, DECODE, EXEC, MEM, WB, HALT.
REQ-016 FETCH: latch opcode1/opcode2 into IR1/IR2; next DECODE.
REQ-017 DECODE: drive rf_raddr_a/b from IR fields; NOP -> FETCH; LOADI -> WB; ADD -> EXEC; STORE -> MEM; HALT -> HALT; illegal -> HALT and set illegal.
REQ-018 EXEC: one cycle, ALU inputs valid; next WB.
REQ-019 WB: rf_we=1 for exactly one cycle, rf_waddr=rd, wb_sel=0 for LOADI, 1 for ADD; next FETCH.
REQ-020 MEM: mem_we=1, mem_addr=IR2, rf_raddr_a=rs held stable until mem_ready=1; leave to FETCH on the cycle mem_ready=1; no timeout.
REQ-021 PC SHALL increment by 2, modulo 256, on every transition into FETCH from DECODE, WB or MEM; PC 254 -> 0.
REQ-022 Latency: NOP 2 cycles, LOADI 3, ADD 4, STORE 2 + mem wait cycles (>= 3 total).
REQ-023 HALT: absorbing; PC frozen; rf_we=0, mem_we=0; halted=1; exit only by reset.
REQ-024 rf_we and mem_we SHALL never be asserted in the same cycle and SHALL be 0 outside WB/MEM respectively.
REQ-025 illegal SHALL remain set until reset.

Reset
REQ-026 While reset=1: state=FETCH, PC=0, IR1=IR2=0, rf_we=0, mem_we=0, mem_addr=0, halted=0, illegal=0, wb_sel=0, imm=0.
REQ-027 Reset asserted mid-instruction (including MEM wait) SHALL abort it immediately with no further rf_we/mem_we pulse.
REQ-028 First FETCH latch SHALL occur on the first rising clk after reset deasserts.

Structure
REQ-029 Shared package cpu_pkg SHALL hold the state enum, 4-bit opcode constants (OP_NOP, OP_LOADI, OP_ADD, OP_STORE, OP_HALT) and PC step constant (2).
REQ-030 One combinational sub-module instr_decode SHALL map IR1/IR2 to op class, rd, rs1, rs2, imm, illegal; FSM and PC stay in cpu_control.

Verification
REQ-031 Program NOP,NOP,HALT at 0,2,4 -> PC 0,2,4 then frozen at 4, halted=1 by cycle 5 after reset, no rf_we/mem_we.
REQ-032 LOADI r0,0xFF at PC 2 -> one rf_we pulse, rf_waddr=0, wb_sel=0, imm=0xFF, 3 cycles after its FETCH, PC then 4.
REQ-033 ADD IR1=0x80, IR2=0x13 -> rf_raddr_a=0, rf_raddr_b=1, rf_we at 4th cycle with rf_waddr=3, wb_sel=1.
REQ-034 STORE IR1=0x33, IR2=0x82, mem_ready low 3 cycles -> mem_we=1, mem_addr=0x82, rf_raddr_a=3 held 4 cycles, single transition to FETCH, PC+2.
REQ-035 Opcode 0x50 -> illegal=1, halted=1, PC frozen; reset pulse clears both, PC=0.
REQ-036 Reset asserted during STORE wait -> mem_we drops asynchronously, PC=0; and NOP at PC 254 -> PC wraps to 0.
